alu_sequencer: RTL and testbench
================================

# alu_sequencer

Front-end sequencer that sits directly upstream of the 8-bit multi-cycle ALU. It accepts one operation request (opcode plus two 8-bit operands) over a valid/ready handshake. It serialises the operands onto the ALU's single `inbus` using the start/A/M loading sequence, waits for `finish`, and captures the one- or two-byte result from `outbus`. It then returns the result over a valid/ready response channel, with a watchdog that turns a missing `finish` into an error response.

## Interface
- `TIMEOUT`, default 64: maximum number of cycles spent in LOAD_M waiting for `alu_finish` before an error response is issued. Legal range is 2..255.
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  a request is present on the `req_*` inputs.
- `req_ready`  output  1  the block can accept a request; equals `state==IDLE`.
- `req_op`  input  2  operation code: 00 add, 01 sub, 10 mul, 11 div.
- `req_a`  input  8  first operand, loaded into ALU register A.
- `req_b`  input  8  second operand, loaded into ALU register M.
- `rsp_valid`  output  1  a response is held on the `rsp_*` outputs.
- `rsp_ready`  input  1  the consumer accepts the response.
- `rsp_data`  output  16  result; add/sub results are zero-extended; for mul/div, `[15:8]` holds the first byte and `[7:0]` the second byte.
- `rsp_err`  output  1  the watchdog expired; `rsp_data` is 0 when this is set.
- `alu_start`  output  1  start strobe to the ALU.
- `alu_sel`  output  2  operation select to the ALU.
- `alu_inbus`  output  8  operand bus to the ALU.
- `alu_outbus`  input  8  result bus from the ALU.
- `alu_finish`  input  1  ALU completion flag.
- `busy`  output  1  `state!=IDLE`.

## Operation
- States are IDLE, LOAD_A, HOLD_A, LOAD_M, CAPT2 and RESP; the reset state is IDLE.
- **IDLE:** on `req_valid & req_ready`, latch `req_op`, `req_a` and `req_b`, clear the watchdog, and go to LOAD_A.
- **LOAD_A** (one cycle): `alu_start=1`, `alu_sel=op`, `alu_inbus=a`; then go to HOLD_A.
- **HOLD_A** (one cycle): `alu_start=0`, `alu_inbus=a`, `alu_sel=op`; then go to LOAD_M.
- **LOAD_M:** `alu_inbus=b` and `alu_sel=op`. The watchdog increments every cycle. Exits:
  - `alu_finish=1` with op 00/01: capture `{8'h00, alu_outbus}` and go to RESP.
  - `alu_finish=1` with op 10/11: capture `alu_outbus` into `[15:8]` and go to CAPT2.
  - Watchdog reaches `TIMEOUT-1` without `alu_finish`: set `rsp_err=1`, set `rsp_data=0`, and go to RESP.
  - When `alu_finish` and expiry happen in the same cycle, `finish` wins and no error is raised.
- **CAPT2** (one cycle): capture `alu_outbus` into `[7:0]` unconditionally, then go to RESP.
- **RESP:** `rsp_valid=1`. On `rsp_ready`, go to IDLE and clear `rsp_err`. `rsp_data` holds its value until the next capture.
- `alu_finish` is ignored in IDLE, LOAD_A, HOLD_A and RESP.
- All `alu_*` and `rsp_*` outputs are registered or decoded from the state only. There is no combinational path from `req_*` or `alu_*` inputs to any output.
- While in IDLE, `alu_inbus` and `alu_sel` are driven to 0.

## Timing
- **Reset values:**
  - `alu_start=0`, `alu_sel=0`, `alu_inbus=0`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`.
  - `req_ready=1`, because the block is in IDLE.
- **Request acceptance:** a request accepted at edge k produces `alu_start=1` during cycle k+1. Operand A is on the bus during cycles k+1 and k+2. Operand M is on the bus from cycle k+3.
- **Response latency:** if `finish` is first high in LOAD_M cycle j (j=0 is the first LOAD_M cycle), `rsp_valid` rises at:
  - edge k+4+j for add/sub;
  - edge k+5+j for mul/div.
- **Back-to-back requests:** the earliest next acceptance is the cycle after the RESP handshake. There is no overlap between requests.
- **Error timing:** an error response appears `TIMEOUT` cycles after entry into LOAD_M.
- **Reset mid-operation:** the block returns to IDLE immediately and asynchronously. `alu_start` deasserts, the in-flight request is dropped, and no response is produced.
- **Held response:** `rsp_valid` stays high with stable data for any number of cycles with `rsp_ready=0`.

## Test plan
- **Add:** op=00, a=40, b=12, and the ALU model asserts `finish` with `outbus`=52 after 3 LOAD_M cycles. Required: `alu_start` is high for exactly 1 cycle with `inbus`=40 and `sel`=00; `inbus`=40 in the next cycle; `inbus`=12 from then on; the response is `rsp_data`=0x0034 with `rsp_err`=0.
- **Sub:** op=01, a=40, b=12, `outbus`=28. Required: `rsp_data`=0x001C, with `alu_sel`=01 held from LOAD_A through LOAD_M.
- **Mul:** op=10, a=40, b=12, and the model returns 0x01 then 0xE0 on consecutive cycles. Required: `rsp_data`=0x01E0, with `rsp_valid` one cycle later than in the add case.
- **Timeout:** `TIMEOUT`=8 and the model never asserts `finish`. Required: `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 8 cycles after LOAD_M entry; `finish` pulsed in the same cycle as expiry instead yields a normal response.
- **Backpressure and ordering:** `rsp_ready` is held low for 10 cycles, then two requests are issued back-to-back. Required: data stays stable while stalled; `req_ready`=0 throughout; the second start occurs only after the first handshake.
- **Reset mid-operation and spurious finish:** pull `rst` low during LOAD_M. Required: every output returns to its reset value within the same cycle, there is no response, and a subsequent request completes normally. Separately, a spurious `finish` pulse while in IDLE has no effect.

Source files
------------

// File: rtl/alu_sequencer.sv
// Valid/ready front end for the 8-bit multi-cycle ALU: loads A then M over inbus,
// collects a one- or two-byte result and turns a missing finish into an error response.
module alu_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [1:0]  alu_sel,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_finish,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD_A, HOLD_A, LOAD_M, CAPT2, RESP} state_e;

  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  wd_q, wd_d;
  logic        start_q, start_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  inbus_q, inbus_d;
  logic        rspValid_q, rspValid_d;
  logic [15:0] rspData_q, rspData_d;
  logic        rspErr_q, rspErr_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    wd_d       = wd_q;
    start_d    = start_q;
    sel_d      = sel_q;
    inbus_d    = inbus_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspErr_d   = rspErr_q;

    unique case (state_q)
      IDLE: begin
        start_d = 1'b0;
        sel_d   = 2'b00;
        inbus_d = 8'h00;
        if (req_valid) begin
          op_d    = req_op;
          b_d     = req_b;
          wd_d    = 8'h00;
          start_d = 1'b1;
          sel_d   = req_op;
          inbus_d = req_a;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        start_d = 1'b0;
        state_d = HOLD_A;
      end
      HOLD_A: begin
        inbus_d = b_q;
        state_d = LOAD_M;
      end
      LOAD_M: begin
        wd_d = wd_q + 8'd1;
        // finish takes priority over watchdog expiry in the same cycle
        if (alu_finish) begin
          sel_d   = 2'b00;
          inbus_d = 8'h00;
          if (op_q[1]) begin
            rspData_d = {alu_outbus, rspData_q[7:0]};
            state_d   = CAPT2;
          end else begin
            rspData_d  = {8'h00, alu_outbus};
            rspErr_d   = 1'b0;
            rspValid_d = 1'b1;
            state_d    = RESP;
          end
        end else if (wd_q == WdLast) begin
          sel_d      = 2'b00;
          inbus_d    = 8'h00;
          rspData_d  = 16'h0000;
          rspErr_d   = 1'b1;
          rspValid_d = 1'b1;
          state_d    = RESP;
        end
      end
      CAPT2: begin
        rspData_d  = {rspData_q[15:8], alu_outbus};
        rspErr_d   = 1'b0;
        rspValid_d = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          rspErr_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      b_q        <= 8'h00;
      wd_q       <= 8'h00;
      start_q    <= 1'b0;
      sel_q      <= 2'b00;
      inbus_q    <= 8'h00;
      rspValid_q <= 1'b0;
      rspData_q  <= 16'h0000;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      wd_q       <= wd_d;
      start_q    <= start_d;
      sel_q      <= sel_d;
      inbus_q    <= inbus_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_err   = rspErr_q;
  assign alu_start = start_q;
  assign alu_sel   = sel_q;
  assign alu_inbus = inbus_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: plays the ALU side in lock-step and checks handshakes,
// bus sequencing, latency, watchdog, backpressure and asynchronous reset.
module tb_alu_sequencer;

  localparam int Timeout = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_start;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_finish;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_sequencer #(.TIMEOUT(Timeout)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_start  (alu_start),
    .alu_sel    (alu_sel),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_finish (alu_finish),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // What an ideal ALU would return: add/sub one byte, mul/div two bytes (high/quotient first).
  function automatic logic [15:0] refResult(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    case (op)
      2'd0:    return {8'h00, 8'(a + b)};
      2'd1:    return {8'h00, 8'(a - b)};
      2'd2:    return 16'(a) * 16'(b);
      default: return (b == 8'h00) ? {8'hFF, a} : {8'(a / b), 8'(a % b)};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_start"}, 16'(alu_start), 16'd0);
    checkOutput({tag, "_sel"},   16'(alu_sel),   16'd0);
    checkOutput({tag, "_inbus"}, 16'(alu_inbus), 16'd0);
    checkOutput({tag, "_valid"}, 16'(rsp_valid), 16'd0);
    checkOutput({tag, "_data"},  rsp_data,       16'd0);
    checkOutput({tag, "_err"},   16'(rsp_err),   16'd0);
    checkOutput({tag, "_busy"},  16'(busy),      16'd0);
    checkOutput({tag, "_ready"}, 16'(req_ready), 16'd1);
  endtask

  // One full transaction. fc = LOAD_M cycle index in which the ALU raises finish (-1: never).
  // hold = cycles the response is stalled while a competing request is offered.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                               input int fc, input int hold);
    logic [15:0] expData;
    logic        expErr;
    int          expAt;
    int          lastLoad;
    int          seenAt;

    expErr   = (fc < 0);
    expData  = expErr ? 16'h0000 : refResult(op, a, b);
    lastLoad = expErr ? Timeout - 1 : fc;
    expAt    = expErr ? Timeout : (op[1] ? fc + 2 : fc + 1);

    checkOutput("acc_ready", 16'(req_ready), 16'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    checkOutput("loadA_start", 16'(alu_start), 16'd1);
    checkOutput("loadA_inbus", 16'(alu_inbus), 16'(a));
    checkOutput("loadA_sel",   16'(alu_sel),   16'(op));
    checkOutput("loadA_busy",  16'(busy),      16'd1);
    checkOutput("loadA_ready", 16'(req_ready), 16'd0);
    @(negedge clk);
    checkOutput("holdA_start", 16'(alu_start), 16'd0);
    checkOutput("holdA_inbus", 16'(alu_inbus), 16'(a));
    checkOutput("holdA_sel",   16'(alu_sel),   16'(op));

    seenAt = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      alu_finish = 1'b0;
      alu_outbus = 8'($urandom);
      if (rsp_valid) begin
        seenAt = c;
        break;
      end
      if (c <= lastLoad) begin
        checkOutput("loadM_inbus", 16'(alu_inbus), 16'(b));
        checkOutput("loadM_sel",   16'(alu_sel),   16'(op));
        checkOutput("loadM_start", 16'(alu_start), 16'd0);
      end
      if (c == fc) begin
        alu_finish = 1'b1;
        alu_outbus = op[1] ? expData[15:8] : expData[7:0];
      end else if (fc >= 0 && c == fc + 1 && op[1]) begin
        alu_outbus = expData[7:0];
      end
    end
    checkOutput("rsp_latency", 16'(seenAt), 16'(expAt));
    checkOutput("rsp_data",    rsp_data,    expData);
    checkOutput("rsp_err",     16'(rsp_err), 16'(expErr));

    for (int h = 0; h < hold; h++) begin
      req_valid  = 1'b1;
      req_op     = 2'($urandom);
      alu_finish = 1'($urandom);
      alu_outbus = 8'($urandom);
      @(negedge clk);
      checkOutput("stall_valid", 16'(rsp_valid), 16'd1);
      checkOutput("stall_data",  rsp_data,       expData);
      checkOutput("stall_err",   16'(rsp_err),   16'(expErr));
      checkOutput("stall_ready", 16'(req_ready), 16'd0);
      checkOutput("stall_start", 16'(alu_start), 16'd0);
    end
    alu_finish = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("done_valid", 16'(rsp_valid), 16'd0);
    checkOutput("done_err",   16'(rsp_err),   16'd0);
    checkOutput("done_ready", 16'(req_ready), 16'd1);
    checkOutput("done_data",  rsp_data,       expData);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 8'h00;
    req_b      = 8'h00;
    rsp_ready  = 1'b0;
    alu_outbus = 8'h00;
    alu_finish = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("afterReset");

    // A finish pulse with no request outstanding must not start anything.
    alu_finish = 1'b1;
    alu_outbus = 8'hA5;
    @(negedge clk);
    alu_finish = 1'b0;
    @(negedge clk);
    checkResetOutputs("spurious");

    applyStimulus(2'b00, 8'd40, 8'd12, 3, 0);
    applyStimulus(2'b01, 8'd40, 8'd12, 3, 0);
    applyStimulus(2'b10, 8'd40, 8'd12, 3, 0);
    applyStimulus(2'($urandom), 8'($urandom), 8'($urandom), -1, 2);
    applyStimulus(2'b00, 8'($urandom), 8'($urandom), Timeout - 1, 0);
    applyStimulus(2'b10, 8'($urandom), 8'($urandom), Timeout - 1, 0);

    applyStimulus(2'b10, 8'($urandom), 8'($urandom), 1, 10);
    applyStimulus(2'b11, 8'($urandom), 8'($urandom), 0, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, Timeout - 2)), int'($urandom_range(0, 3)));
    end

    // Reset pulled mid-way through LOAD_M: outputs clear at once, no response follows.
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_a     = 8'd7;
    req_b     = 8'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("preRst_busy", 16'(busy), 16'd1);
    #2 rst = 1'b0;
    alu_finish = 1'b1;
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_finish = 1'b0;
      checkOutput("postRst_valid", 16'(rsp_valid), 16'd0);
      checkOutput("postRst_busy",  16'(busy),      16'd0);
    end
    applyStimulus(2'b00, 8'd40, 8'd12, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
